// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared state encoding, port indices and elaboration helpers
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    READ
  } state_e;

  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_VOICE = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: combinational two-way round-robin pick between CPU and voice ports
module sram_rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

  // a lone requester always wins; a tie goes to the port that was not served last
  always_comb begin
    valid  = |req;
    winner = (req[PORT_CPU] && req[PORT_VOICE]) ? ~last_grant : req[PORT_VOICE];
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences a shared asynchronous SRAM for two round-robin requesters
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int WE_CYCLES  = 2,
  parameter int RD_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvalid,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_data_oe,
  input  logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_we_n,
  output logic                  sram_oe_n
);

  localparam int CNT_W = $clog2(max2(WE_CYCLES, RD_CYCLES) + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rv_q, rv_d;
  logic                  busy_q, busy_d;
  logic                  we_n_q, we_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  data_oe_q, data_oe_d;

  logic                  win;
  logic                  win_valid;
  logic                  take;
  logic                  last_beat;

  sram_rr_arb2 u_arb (
    .req        ({p1_req, p0_req}),
    .last_grant (last_q),
    .winner     (win),
    .valid      (win_valid)
  );

  assign take      = (state_q == IDLE) && win_valid;
  assign last_beat = cnt_q == CNT_W'(1);

  // state and every output flop; reset forces strobes inactive without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= PORT_VOICE;
      owner_q   <= PORT_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      rd_q      <= '0;
      gnt_q     <= '0;
      rv_q      <= '0;
      busy_q    <= 1'b0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rd_q      <= rd_d;
      gnt_q     <= gnt_d;
      rv_q      <= rv_d;
      busy_q    <= busy_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      data_oe_q <= data_oe_d;
    end
  end

  // next state plus transaction capture; address and write data move only when leaving IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = SETUP;
          last_d  = win;
          owner_d = win;
          we_d    = win ? p1_we : p0_we;
          addr_d  = win ? p1_addr : p0_addr;
          dout_d  = win ? p1_wdata : p0_wdata;
        end
      end
      SETUP: begin
        state_d = we_q ? WRITE : READ;
        cnt_d   = we_q ? CNT_W'(WE_CYCLES) : CNT_W'(RD_CYCLES);
      end
      WRITE: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = last_beat ? HOLD : WRITE;
      end
      HOLD: state_d = IDLE;
      READ: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = last_beat ? IDLE : READ;
        rd_d    = last_beat ? sram_din : rd_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // strobes are decoded from the next state so they leave a flop directly and cannot glitch
  always_comb begin
    busy_d    = state_d != IDLE;
    we_n_d    = state_d != WRITE;
    oe_n_d    = state_d != READ;
    data_oe_d = we_d && (state_d inside {SETUP, WRITE, HOLD});
    gnt_d     = {2{take}} & {win, ~win};
    rv_d      = {2{(state_q == READ) && last_beat}} & {owner_q, ~owner_q};
  end

  assign p0_gnt       = gnt_q[PORT_CPU];
  assign p1_gnt       = gnt_q[PORT_VOICE];
  assign p0_rvalid    = rv_q[PORT_CPU];
  assign p1_rvalid    = rv_q[PORT_VOICE];
  assign rd_data      = rd_q;
  assign busy         = busy_q;
  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_data_oe = data_oe_q;
  assign sram_we_n    = we_n_q;
  assign sram_oe_n    = oe_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed + scoreboard bench, default instance and a WE=1/RD=3 instance
module tb_sram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [1:0]    req[2];
  logic [1:0]    we[2];
  logic [AW-1:0] addr[2][2];
  logic [DW-1:0] wdata[2][2];
  logic          gnt0[2], gnt1[2], rv0[2], rv1[2];
  logic          busy[2], data_oe[2], we_n[2], oe_n[2];
  logic [DW-1:0] rd_data[2], sram_dout[2], sram_din[2];
  logic [AW-1:0] sram_addr[2];
  logic [DW-1:0] mem[2][2048];

  sb_t q0[$];
  sb_t q1[$];
  int  passed = 0;
  int  total = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic push(input int g, input logic p, input logic [DW-1:0] d);
    sb_t e;
    e.port = p;
    e.data = d;
    if (g == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic sb_t pop(input int g);
    return (g == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic          pv = 1'b0;
    sb_t           e;

    sram_arbiter #(
      .WE_CYCLES (g == 0 ? 2 : 1),
      .RD_CYCLES (g == 0 ? 2 : 3)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .p0_req       (req[g][0]),
      .p0_we        (we[g][0]),
      .p0_addr      (addr[g][0]),
      .p0_wdata     (wdata[g][0]),
      .p1_req       (req[g][1]),
      .p1_we        (we[g][1]),
      .p1_addr      (addr[g][1]),
      .p1_wdata     (wdata[g][1]),
      .p0_gnt       (gnt0[g]),
      .p1_gnt       (gnt1[g]),
      .p0_rvalid    (rv0[g]),
      .p1_rvalid    (rv1[g]),
      .rd_data      (rd_data[g]),
      .busy         (busy[g]),
      .sram_addr    (sram_addr[g]),
      .sram_dout    (sram_dout[g]),
      .sram_data_oe (data_oe[g]),
      .sram_din     (sram_din[g]),
      .sram_we_n    (we_n[g]),
      .sram_oe_n    (oe_n[g])
    );

    assign sram_din[g] = oe_n[g] ? '0 : mem[g][sram_addr[g]];

    always @(posedge we_n[g]) if (data_oe[g]) mem[g][sram_addr[g]] <= sram_dout[g];

    always @(negedge clk) begin
      if (!rst_n) pv <= 1'b0;
      else begin
        chkb("both_strobes_low", !we_n[g] && !oe_n[g], 1'b0);
        chkb("we_without_drive", !we_n[g] && !data_oe[g], 1'b0);
        chkb("drive_during_read", data_oe[g] && !oe_n[g], 1'b0);
        if (pv) chkb("addr_dout_moved", (sram_addr[g] !== pa || sram_dout[g] !== pd) && !gnt0[g] && !gnt1[g], 1'b0);
        pa <= sram_addr[g];
        pd <= sram_dout[g];
        pv <= 1'b1;
        if (rv0[g] || rv1[g]) begin
          chkb("rv_both", rv0[g] && rv1[g], 1'b0);
          chkb("rv_expected", qsize(g) != 0, 1'b1);
          if (qsize(g) != 0) begin
            e = pop(g);
            chkb("rv_port", rv1[g], e.port);
            chk("rd_data", 32'(rd_data[g]), 32'(e.data));
          end
        end
      end
    end
  end

  task automatic run(input int g, input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k = 0;
    int gk = 0;
    int rk = 0;
    int wl = 0;
    int ol = 0;
    int bad = 0;
    int wc = (g == 0) ? 2 : 1;
    int rc = (g == 0) ? 2 : 3;
    addr[g][p] = a;
    wdata[g][p] = d;
    we[g][p] = w;
    req[g][p] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      k++;
      if (gk == 0 && (p ? gnt1[g] : gnt0[g])) begin
        gk = k;
        req[g][p] = 1'b0;
        if (!w) push(g, p, d);
      end
      if (gk != 0 && busy[g] && (sram_addr[g] !== a || (w && sram_dout[g] !== d))) bad++;
      if (!we_n[g]) wl++;
      if (!oe_n[g]) ol++;
      if (p ? rv1[g] : rv0[g]) rk = k;
      if (gk != 0 && !busy[g]) break;
    end
    req[g][p] = 1'b0;
    chk("gnt_latency", gk, 1);
    chkb("txn_done", busy[g], 1'b0);
    chk("addr_data_stable", bad, 0);
    if (w) begin
      chk("we_low_cycles", wl, wc);
      chk("oe_during_write", ol, 0);
      chk("write_length", k, wc + 3);
    end else begin
      chk("oe_low_cycles", ol, rc);
      chk("we_during_read", wl, 0);
      chk("rvalid_latency", rk, rc + 2);
    end
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 50 && busy[g]; i++) begin
      @(posedge clk);
      #1;
    end
    chkb("idle_timeout", busy[g], 1'b0);
  endtask

  initial begin
    int            n;
    int            rvc;
    logic          exp_p;
    logic          gap;
    logic          saw;
    logic          done;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int g = 0; g < 2; g++) begin
      req[g] = '0;
      we[g] = '0;
      for (int p = 0; p < 2; p++) begin
        addr[g][p] = '0;
        wdata[g][p] = '0;
      end
    end
    #1 rst_n = 1'b0;
    #2;
    for (int g = 0; g < 2; g++) begin
      chkb("rst_we_n", we_n[g], 1'b1);
      chkb("rst_oe_n", oe_n[g], 1'b1);
      chkb("rst_data_oe", data_oe[g], 1'b0);
      chkb("rst_busy", busy[g], 1'b0);
      chk("rst_pulses", {28'd0, gnt0[g], gnt1[g], rv0[g], rv1[g]}, 0);
      chk("rst_addr", 32'(sram_addr[g]), 0);
      chk("rst_dout", 32'(sram_dout[g]), 0);
      chk("rst_rd_data", 32'(rd_data[g]), 0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(0, 1'b0, 1'b1, 11'h123, 8'hA5);
    run(0, 1'b1, 1'b0, 11'h123, 8'hA5);
    addr[0][0] = 11'h200;
    wdata[0][0] = 8'h5A;
    we[0][0] = 1'b1;
    req[0][0] = 1'b1;
    n = 0;
    while (n < 10 && we_n[0] !== 1'b0) begin
      @(posedge clk);
      #1;
      n++;
      if (gnt0[0]) req[0][0] = 1'b0;
    end
    chkb("abort_in_write", we_n[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chkb("abort_we_n", we_n[0], 1'b1);
    chkb("abort_data_oe", data_oe[0], 1'b0);
    chkb("abort_busy", busy[0], 1'b0);
    chkb("abort_oe_n", oe_n[0], 1'b1);
    req[0] = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rvc = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rv0[0] || rv1[0]) rvc++;
    end
    chk("abort_no_rvalid", rvc, 0);
    run(0, 1'b1, 1'b0, 11'h123, 8'hA5);
    addr[0][0] = 11'h001;
    wdata[0][0] = 8'h11;
    addr[0][1] = 11'h002;
    wdata[0][1] = 8'h22;
    we[0] = 2'b11;
    req[0] = 2'b11;
    n = 0;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(posedge clk);
      #1;
      if (gnt0[0] || gnt1[0]) begin
        chkb("tie_order", gnt1[0], n[0]);
        req[0][gnt1[0]] = 1'b0;
        n++;
      end
    end
    chk("tie_count", n, 2);
    wait_idle(0);
    we[0] = 2'b00;
    req[0] = 2'b11;
    n = 0;
    exp_p = 1'b0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      @(posedge clk);
      #1;
      if (gnt0[0] || gnt1[0]) begin
        chkb("rr_single_gnt", gnt0[0] && gnt1[0], 1'b0);
        chkb("rr_order", gnt1[0], exp_p);
        push(0, gnt1[0], gnt1[0] ? 8'h22 : 8'h11);
        exp_p = !exp_p;
        n++;
        if (n == 8) req[0] = 2'b00;
      end
    end
    req[0] = 2'b00;
    chk("rr_count", n, 8);
    wait_idle(0);
    addr[0][1] = 11'h002;
    we[0][1] = 1'b0;
    req[0][1] = 1'b1;
    gap = 1'b0;
    saw = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (gnt1[0] && req[0][1]) begin
        req[0][1] = 1'b0;
        push(0, 1'b1, 8'h22);
        addr[0][0] = 11'h003;
        wdata[0][0] = 8'h33;
        we[0][0] = 1'b1;
        req[0][0] = 1'b1;
      end
      if (gnt0[0]) req[0][0] = 1'b0;
      if (!oe_n[0]) saw = 1'b1;
      if (saw && !busy[0] && we_n[0] && oe_n[0]) gap = 1'b1;
      if (data_oe[0]) begin
        chkb("turnaround_gap", gap, 1'b1);
        chkb("turnaround_oe_n", oe_n[0], 1'b1);
        done = 1'b1;
        break;
      end
    end
    req[0] = 2'b00;
    chkb("turnaround_seen", done, 1'b1);
    wait_idle(0);
    run(0, 1'b1, 1'b0, 11'h003, 8'h33);
    for (int i = 0; i < 256; i++) begin
      a = AW'($urandom_range(0, 2047));
      d = DW'($urandom_range(0, 255));
      run(1, 1'($urandom_range(0, 1)), 1'b1, a, d);
      run(1, 1'($urandom_range(0, 1)), 1'b0, a, d);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained0", q0.size(), 0);
    chk("sb_drained1", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
